// File: rtl/rm14_encode_tx.sv
// rm14_encode_tx: transmit-side encoder for the (16,5) RM(1,4) link.
// Takes a 5-bit message over valid/ready and builds the systematic 16-bit
// codeword, optionally corrupted by a test error mask. The word is shown in
// parallel, then shifted out one bit per cycle with a start-of-frame flag.
// An optional idle gap follows each frame.
module rm14_encode_tx #(
  parameter bit SER_MSB_FIRST = 1'b0,
  parameter int GAP_CYCLES    = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  input  logic [4:0]  msg,
  input  logic [15:0] err_mask,
  output logic        msg_ready,
  output logic [15:0] codeword,
  output logic        cw_valid,
  output logic        ser_out,
  output logic        ser_valid,
  output logic        ser_sof
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  // Index of the last gap cycle. It is only used when the gap is non-zero.
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic [3:0]  gap_cnt;
  logic [15:0] enc_word;
  logic [15:0] load_word;
  logic        first_bit;
  logic [3:0]  next_cnt;
  logic [3:0]  next_idx;

  // Systematic RM(1,4) mapping.
  // Bits 4:0 carry the message.
  // Bits 14:5 are parities over every 3-subset of the message bits.
  // Bit 15 is the parity over the whole message.
  function automatic logic [15:0] encode(input logic [4:0] m);
    logic [15:0] w;
    w[4:0] = m;
    w[5]   = m[0] ^ m[1] ^ m[2];
    w[6]   = m[0] ^ m[1] ^ m[3];
    w[7]   = m[0] ^ m[1] ^ m[4];
    w[8]   = m[0] ^ m[2] ^ m[3];
    w[9]   = m[0] ^ m[2] ^ m[4];
    w[10]  = m[0] ^ m[3] ^ m[4];
    w[11]  = m[1] ^ m[2] ^ m[3];
    w[12]  = m[1] ^ m[2] ^ m[4];
    w[13]  = m[1] ^ m[3] ^ m[4];
    w[14]  = m[2] ^ m[3] ^ m[4];
    w[15]  = ^m;
    return w;
  endfunction

  assign enc_word  = encode(msg);
  assign load_word = enc_word ^ err_mask;
  assign first_bit = SER_MSB_FIRST ? load_word[15] : load_word[0];
  assign next_cnt  = bit_cnt + 4'd1;
  assign next_idx  = SER_MSB_FIRST ? (4'd15 - next_cnt) : next_cnt;

  // Frame sequencer: accept, 16-bit serialisation, optional gap, all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 4'd0;
      gap_cnt   <= 4'd0;
      msg_ready <= 1'b0;
      codeword  <= 16'd0;
      cw_valid  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_sof   <= 1'b0;
    end else begin
      cw_valid <= 1'b0;
      case (state)
        IDLE: begin
          ser_valid <= 1'b0;
          ser_sof   <= 1'b0;
          ser_out   <= 1'b0;
          if (msg_valid && msg_ready) begin
            codeword  <= load_word;
            cw_valid  <= 1'b1;
            msg_ready <= 1'b0;
            ser_valid <= 1'b1;
            ser_sof   <= 1'b1;
            ser_out   <= first_bit;
            bit_cnt   <= 4'd0;
            state     <= SHIFT;
          end else begin
            msg_ready <= 1'b1;
          end
        end
        SHIFT: begin
          ser_sof <= 1'b0;
          if (bit_cnt == 4'd15) begin
            ser_valid <= 1'b0;
            ser_out   <= 1'b0;
            bit_cnt   <= 4'd0;
            gap_cnt   <= 4'd0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
            end else begin
              state     <= IDLE;
              msg_ready <= 1'b1;
            end
          end else begin
            bit_cnt <= next_cnt;
            ser_out <= codeword[next_idx];
          end
        end
        GAP: begin
          ser_valid <= 1'b0;
          ser_sof   <= 1'b0;
          ser_out   <= 1'b0;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt   <= 4'd0;
            msg_ready <= 1'b1;
            state     <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rm14_encode_tx.sv
// tb_rm14_encode_tx: self-checking bench for rm14_encode_tx.
// Instance 0: LSB-first serialisation, no gap.
// Instance 1: MSB-first serialisation, 3-cycle gap.
// Stimulus is driven, and outputs sampled, on the falling clock edge.
module tb_rm14_encode_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     [2];
  logic        msg_valid [2];
  logic [4:0]  msg       [2];
  logic [15:0] err_mask  [2];
  logic        msg_ready [2];
  logic [15:0] codeword  [2];
  logic        cw_valid  [2];
  logic        ser_out   [2];
  logic        ser_valid [2];
  logic        ser_sof   [2];

  int errors = 0;
  int checks = 0;

  localparam int GAP_B = 3;

  rm14_encode_tx #(.SER_MSB_FIRST(1'b0), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n[0]), .msg_valid(msg_valid[0]), .msg(msg[0]),
    .err_mask(err_mask[0]), .msg_ready(msg_ready[0]), .codeword(codeword[0]),
    .cw_valid(cw_valid[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_sof(ser_sof[0])
  );

  rm14_encode_tx #(.SER_MSB_FIRST(1'b1), .GAP_CYCLES(GAP_B)) dut_b (
    .clk(clk), .rst_n(rst_n[1]), .msg_valid(msg_valid[1]), .msg(msg[1]),
    .err_mask(err_mask[1]), .msg_ready(msg_ready[1]), .codeword(codeword[1]),
    .cw_valid(cw_valid[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_sof(ser_sof[1])
  );

  function automatic int gap_of(input int sel);
    return (sel == 1) ? GAP_B : 0;
  endfunction

  function automatic bit msb_of(input int sel);
    return (sel == 1);
  endfunction

  // Reference codeword: message bits, then the parity of every 3-subset of
  // the message in lexicographic order, then the overall parity.
  function automatic logic [15:0] ref_encode(input logic [4:0] m);
    logic [15:0] cw;
    int k;
    cw = '0;
    for (int i = 0; i < 5; i++) cw[i] = m[i];
    k = 5;
    for (int a = 0; a < 5; a++)
      for (int b = a + 1; b < 5; b++)
        for (int c = b + 1; c < 5; c++) begin
          cw[k] = m[a] ^ m[b] ^ m[c];
          k++;
        end
    cw[15] = ^m;
    return cw;
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full frame on instance sel. Called on a falling edge while the DUT is idle.
  task automatic applyStimulus(input int sel, input logic [4:0] m,
                               input logic [15:0] mask, input logic [15:0] exp_cw);
    logic [15:0] exp_ser, ser_vec, sof_vec, vld_vec, cwv_vec, rdy_vec;
    logic        gap_busy;
    for (int n = 0; n < 16; n++)
      exp_ser[n] = msb_of(sel) ? exp_cw[15 - n] : exp_cw[n];
    checkOutput("ready_before", 16'(msg_ready[sel]), 16'd1);
    msg[sel]       = m;
    err_mask[sel]  = mask;
    msg_valid[sel] = 1'b1;
    @(negedge clk);
    msg_valid[sel] = 1'b0;
    msg[sel]       = 5'($urandom);
    err_mask[sel]  = 16'($urandom);
    checkOutput("codeword", codeword[sel], exp_cw);
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      ser_vec[n] = ser_out[sel];
      sof_vec[n] = ser_sof[sel];
      vld_vec[n] = ser_valid[sel];
      cwv_vec[n] = cw_valid[sel];
      rdy_vec[n] = msg_ready[sel];
    end
    checkOutput("serial_bits", ser_vec, exp_ser);
    checkOutput("sof_pattern", sof_vec, 16'h0001);
    checkOutput("valid_pattern", vld_vec, 16'hFFFF);
    checkOutput("cw_valid_pulse", cwv_vec, 16'h0001);
    checkOutput("ready_busy", rdy_vec, 16'h0000);
    gap_busy = 1'b0;
    for (int g = 0; g < gap_of(sel); g++) begin
      @(negedge clk);
      gap_busy = gap_busy | ser_valid[sel] | ser_out[sel] | msg_ready[sel] | ser_sof[sel];
    end
    if (gap_of(sel) > 0) checkOutput("gap_quiet", 16'(gap_busy), 16'd0);
    @(negedge clk);
    checkOutput("ready_after", 16'(msg_ready[sel]), 16'd1);
    checkOutput("idle_valid", 16'(ser_valid[sel]), 16'd0);
    checkOutput("codeword_held", codeword[sel], exp_cw);
  endtask

  initial begin
    logic [4:0]  rm;
    logic [15:0] rmask;
    int          pulses;
    int          pulse_cyc [3];
    logic [4:0]  cur_m;

    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; msg_valid[s] = 1'b0; msg[s] = '0; err_mask[s] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checkOutput("reset_outputs",
                  {11'd0, msg_ready[s], cw_valid[s], ser_out[s], ser_valid[s], ser_sof[s]}, 16'd0);
      checkOutput("reset_codeword", codeword[s], 16'd0);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(negedge clk);
    checkOutput("ready_post_reset_a", 16'(msg_ready[0]), 16'd1);
    checkOutput("ready_post_reset_b", 16'(msg_ready[1]), 16'd1);

    // Directed frames, LSB-first instance.
    applyStimulus(0, 5'b00000, 16'h0000, 16'h0000);
    applyStimulus(0, 5'b00001, 16'h0000, 16'h87E1);
    applyStimulus(0, 5'b00010, 16'h0000, 16'hB8E2);
    applyStimulus(0, 5'b11111, 16'h0000, 16'hFFFF);
    applyStimulus(0, 5'b00001, 16'h0004, 16'h87E5);
    // Directed frames, MSB-first instance with gap.
    applyStimulus(1, 5'b00001, 16'h0000, 16'h87E1);
    applyStimulus(1, 5'b00010, 16'h0000, 16'hB8E2);
    applyStimulus(1, 5'b11111, 16'h0000, 16'hFFFF);

    // Random messages and masks against the reference model.
    for (int i = 0; i < 12; i++) begin
      rm    = 5'($urandom);
      rmask = (i % 3 == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(i % 2, rm, rmask, ref_encode(rm) ^ rmask);
    end

    // msg_valid held high on the gapped instance: accepts spaced 17+gap apart.
    pulses = 0;
    pulse_cyc = '{-100, -100, -100};
    cur_m = 5'($urandom);
    msg[1] = cur_m; err_mask[1] = 16'h0000; msg_valid[1] = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (cw_valid[1]) begin
        if (pulses < 3) pulse_cyc[pulses] = cyc;
        pulses++;
        checkOutput("b2b_codeword", codeword[1], ref_encode(cur_m));
        cur_m = 5'($urandom);
        msg[1] = cur_m;
        if (pulses == 3) msg_valid[1] = 1'b0;
      end
    end
    checkOutput("b2b_pulse_count", 16'(pulses), 16'd3);
    checkOutput("b2b_spacing_1", 16'(pulse_cyc[1] - pulse_cyc[0]), 16'(17 + GAP_B));
    checkOutput("b2b_spacing_2", 16'(pulse_cyc[2] - pulse_cyc[1]), 16'(17 + GAP_B));

    // Reset in the middle of a frame, during serial bit 7.
    checkOutput("ready_before_abort", 16'(msg_ready[0]), 16'd1);
    msg[0] = 5'b10110; err_mask[0] = 16'h0000; msg_valid[0] = 1'b1;
    @(negedge clk);
    msg_valid[0] = 1'b0;
    for (int n = 1; n <= 7; n++) @(negedge clk);
    checkOutput("abort_pre_valid", 16'(ser_valid[0]), 16'd1);
    #2 rst_n[0] = 1'b0;
    #1;
    checkOutput("abort_outputs",
                {11'd0, msg_ready[0], cw_valid[0], ser_out[0], ser_valid[0], ser_sof[0]}, 16'd0);
    checkOutput("abort_codeword", codeword[0], 16'd0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", 16'(msg_ready[0]), 16'd1);
    checkOutput("abort_no_residual", {14'd0, ser_valid[0], ser_sof[0]}, 16'd0);
    applyStimulus(0, 5'b01101, 16'h0000, ref_encode(5'b01101));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
